// File: rtl/pipe_pkg.sv
// Shared pipeline constants and types used by the operand-forwarding stage and the core.
// Holds default datapath widths, the hard-wired zero register number and the output-slot action encoding.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_LOAD  = 2'd1,
        ACT_DRAIN = 2'd2,
        ACT_FLUSH = 2'd3
    } slot_act_e;

endpackage

// File: rtl/fwd_select.sv
// Single-operand priority search over the in-flight result stages; stage 0 is youngest and wins.
// Purely combinational; reports a block when the winning stage has not produced its result yet.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int AW    = ADDR_W,
    parameter int NSTG  = 2
) (
    input  logic [AW-1:0]         src_addr,
    input  logic [WIDTH-1:0]      src_data,
    input  logic [NSTG-1:0]       fwd_wen,
    input  logic [NSTG*AW-1:0]    fwd_addr,
    input  logic [NSTG*WIDTH-1:0] fwd_data,
    input  logic [NSTG-1:0]       fwd_pending,
    output logic [WIDTH-1:0]      value,
    output logic                  hit,
    output logic                  blocked
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic found;

    always_comb begin
        value   = '0;
        hit     = 1'b0;
        blocked = 1'b0;
        found   = 1'b0;
        if (src_addr != ZERO_ADDR) begin
            value = src_data;
            for (int s = 0; s < NSTG; s++) begin
                // Only the first (youngest) match counts; older pending writers are shadowed.
                if (!found && fwd_wen[s] && (fwd_addr[s*AW +: AW] == src_addr)) begin
                    found = 1'b1;
                    if (fwd_pending[s]) begin
                        blocked = 1'b1;
                    end else begin
                        value = fwd_data[s*WIDTH +: WIDTH];
                        hit   = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/operand_fwd_stage.sv
// Decode-to-execute operand forwarding plus a single-entry valid/ready output register with flush.
// Latency 1 cycle; stalls upstream on load-use hazards or when the held output is not consumed.
module operand_fwd_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int AW    = ADDR_W,
    parameter int NOPS  = 2,
    parameter int NSTG  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NOPS*AW-1:0]    src_addr,
    input  logic [NOPS*WIDTH-1:0] src_data,
    input  logic [NSTG-1:0]       fwd_wen,
    input  logic [NSTG*AW-1:0]    fwd_addr,
    input  logic [NSTG*WIDTH-1:0] fwd_data,
    input  logic [NSTG-1:0]       fwd_pending,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NOPS*WIDTH-1:0] out_data,
    output logic [NOPS-1:0]       out_fwd_hit
);

    logic [NOPS*WIDTH-1:0] sel_data;
    logic [NOPS-1:0]       sel_hit;
    logic [NOPS-1:0]       sel_blocked;

    logic                  out_valid_q, out_valid_d;
    logic [NOPS*WIDTH-1:0] out_data_q,  out_data_d;
    logic [NOPS-1:0]       out_fwd_hit_q, out_fwd_hit_d;

    slot_act_e act;

    for (genvar k = 0; k < NOPS; k++) begin : g_sel
        fwd_select #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .NSTG  (NSTG)
        ) u_fwd_select (
            .src_addr    (src_addr[k*AW +: AW]),
            .src_data    (src_data[k*WIDTH +: WIDTH]),
            .fwd_wen     (fwd_wen),
            .fwd_addr    (fwd_addr),
            .fwd_data    (fwd_data),
            .fwd_pending (fwd_pending),
            .value       (sel_data[k*WIDTH +: WIDTH]),
            .hit         (sel_hit[k]),
            .blocked     (sel_blocked[k])
        );
    end

    assign hazard_stall = in_valid && (|sel_blocked);
    assign in_ready     = !flush && !hazard_stall && (!out_valid_q || out_ready);

    // Flush outranks everything; a simultaneous load and drain is simply a load.
    always_comb begin
        act = ACT_HOLD;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (in_valid && in_ready) begin
            act = ACT_LOAD;
        end else if (out_valid_q && out_ready) begin
            act = ACT_DRAIN;
        end
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_fwd_hit_d = out_fwd_hit_q;
        case (act)
            ACT_LOAD: begin
                out_valid_d   = 1'b1;
                out_data_d    = sel_data;
                out_fwd_hit_d = sel_hit;
            end
            ACT_DRAIN: out_valid_d = 1'b0;
            ACT_FLUSH: out_valid_d = 1'b0;
            default:   out_valid_d = out_valid_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_fwd_hit_q <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_fwd_hit_q <= out_fwd_hit_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_fwd_hit = out_fwd_hit_q;

endmodule

// File: tb/tb_operand_fwd_stage.sv
// Randomised and directed bench for operand_fwd_stage against a behavioural reference model.
module tb_operand_fwd_stage;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NO = 2;
    localparam int NS = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [NO*AW-1:0]   src_addr;
    logic [NO*W-1:0]    src_data;
    logic [NS-1:0]      fwd_wen;
    logic [NS*AW-1:0]   fwd_addr;
    logic [NS*W-1:0]    fwd_data;
    logic [NS-1:0]      fwd_pending;
    logic               flush;
    logic               hazard_stall;
    logic               out_valid;
    logic               out_ready;
    logic [NO*W-1:0]    out_data;
    logic [NO-1:0]      out_fwd_hit;

    int checks = 0;
    int errors = 0;

    logic            m_valid;
    logic [NO*W-1:0] m_data;
    logic [NO-1:0]   m_hit;
    logic [NO*W-1:0] held;

    always #5 clk = ~clk;

    operand_fwd_stage #(.WIDTH(W), .AW(AW), .NOPS(NO), .NSTG(NS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .src_addr     (src_addr),
        .src_data     (src_data),
        .fwd_wen      (fwd_wen),
        .fwd_addr     (fwd_addr),
        .fwd_data     (fwd_data),
        .fwd_pending  (fwd_pending),
        .flush        (flush),
        .hazard_stall (hazard_stall),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_fwd_hit  (out_fwd_hit)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference: the youngest writer of the register decides; scanning oldest-to-youngest
    // and letting each later match overwrite gives the same answer.
    task automatic model_sel(input int k, output logic [W-1:0] v, output logic h, output logic b);
        logic [AW-1:0] a;
        a = src_addr[k*AW +: AW];
        v = src_data[k*W +: W];
        h = 1'b0;
        b = 1'b0;
        if (a == '0) begin
            v = '0;
        end else begin
            for (int s = NS - 1; s >= 0; s--) begin
                if (fwd_wen[s] && fwd_addr[s*AW +: AW] == a) begin
                    b = fwd_pending[s];
                    h = !fwd_pending[s];
                    v = fwd_pending[s] ? src_data[k*W +: W] : fwd_data[s*W +: W];
                end
            end
        end
    endtask

    task automatic cycle();
        logic [NO*W-1:0] e_val;
        logic [NO-1:0]   e_hit;
        logic            any_blk, e_haz, e_rdy, acc, drn;
        logic [W-1:0]    v;
        logic            h, b;
        #1;
        any_blk = 1'b0;
        for (int k = 0; k < NO; k++) begin
            model_sel(k, v, h, b);
            e_val[k*W +: W] = v;
            e_hit[k]        = h;
            any_blk         = any_blk | b;
        end
        e_haz = in_valid && any_blk;
        e_rdy = !flush && !e_haz && (!m_valid || out_ready);
        chk("hazard_stall", {63'd0, hazard_stall}, {63'd0, e_haz});
        chk("in_ready", {63'd0, in_ready}, {63'd0, e_rdy});
        acc = in_valid && e_rdy;
        drn = m_valid && out_ready;
        @(posedge clk);
        if (flush) begin
            m_valid = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_data  = e_val;
            m_hit   = e_hit;
        end else if (drn) begin
            m_valid = 1'b0;
        end
        #1;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
        chk("out_data", out_data, m_data);
        chk("out_fwd_hit", {62'd0, out_fwd_hit}, {62'd0, m_hit});
    endtask

    task automatic idle_inputs();
        in_valid    = 1'b0;
        src_addr    = '0;
        src_data    = '0;
        fwd_wen     = '0;
        fwd_addr    = '0;
        fwd_data    = '0;
        fwd_pending = '0;
        flush       = 1'b0;
        out_ready   = 1'b1;
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_hit   = '0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_fwd_hit", {62'd0, out_fwd_hit}, 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_inputs();
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        flush     = ($urandom_range(0, 15) == 0);
        for (int k = 0; k < NO; k++) begin
            src_addr[k*AW +: AW] = AW'($urandom_range(0, 3));
            src_data[k*W +: W]   = $urandom;
        end
        for (int s = 0; s < NS; s++) begin
            fwd_wen[s]          = $urandom_range(0, 1) != 0;
            fwd_addr[s*AW +: AW] = AW'($urandom_range(0, 3));
            fwd_data[s*W +: W]   = $urandom;
            fwd_pending[s]      = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        idle_inputs();
        m_valid = 1'b0;
        m_data  = '0;
        m_hit   = '0;
        async_reset();

        // Idle after reset
        cycle();
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Priority: both stages write r5, youngest wins
        in_valid = 1'b1;
        src_addr = {5'd3, 5'd5};
        src_data = {32'h0000_0333, 32'h0000_0555};
        fwd_wen  = 2'b11;
        fwd_addr = {5'd5, 5'd5};
        fwd_data = {32'h0000_BBBB, 32'h0000_AAAA};
        cycle();
        chk("prio_data0", {32'd0, out_data[31:0]}, 64'h0000_AAAA);
        chk("prio_hit0", {63'd0, out_fwd_hit[0]}, 64'd1);

        // Zero register never forwards
        src_addr = {5'd0, 5'd2};
        src_data = {32'h0000_1234, 32'h0000_0002};
        fwd_wen  = 2'b01;
        fwd_addr = {5'd9, 5'd0};
        fwd_data = {32'h0, 32'h0000_FFFF};
        cycle();
        chk("zero_data1", {32'd0, out_data[63:32]}, 64'd0);
        chk("zero_hit1", {63'd0, out_fwd_hit[1]}, 64'd0);

        // Load-use: stage 0 pending on r7
        src_addr    = {5'd1, 5'd7};
        src_data    = {32'h11, 32'h77};
        fwd_wen     = 2'b01;
        fwd_addr    = {5'd0, 5'd7};
        fwd_data    = {32'h0, 32'hDEAD};
        fwd_pending = 2'b01;
        repeat (2) begin
            #1;
            chk("lu_stall", {63'd0, hazard_stall}, 64'd1);
            chk("lu_in_ready", {63'd0, in_ready}, 64'd0);
            cycle();
        end
        fwd_pending = 2'b00;
        fwd_data    = {32'h0, 32'h55};
        cycle();
        chk("lu_valid", {63'd0, out_valid}, 64'd1);
        chk("lu_data0", {32'd0, out_data[31:0]}, 64'h55);

        // Backpressure: held output must not move
        fwd_wen   = '0;
        out_ready = 1'b0;
        src_addr  = {5'd2, 5'd1};
        src_data  = {32'hCAFE_0002, 32'hCAFE_0001};
        held      = out_data;
        repeat (3) begin
            cycle();
            chk("bp_held", out_data, held);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_data = {32'h2000_0000 + i, 32'h1000_0000 + i};
            cycle();
            chk("b2b_data0", {32'd0, out_data[31:0]}, {32'd0, 32'h1000_0000 + i});
            chk("b2b_valid", {63'd0, out_valid}, 64'd1);
        end

        // Flush discards held and incoming
        held     = out_data;
        flush    = 1'b1;
        src_data = {32'hF1F1_F1F1, 32'hF0F0_F0F0};
        cycle();
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_nocapture", out_data, held);
        flush = 1'b0;
        in_valid = 1'b0;
        cycle();

        // Random traffic with a mid-run reset while holding an instruction
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
            if (i == 1500) begin
                idle_inputs();
                async_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_fwd_stage.md
# operand_fwd_stage

Parametrised operand-forwarding and pipeline-register stage between decode and execute in the pipelined MIPS core. For each of NOPS source operands it selects, by priority, the newest in-flight result from NSTG later pipeline stages or the register-file value. It detects load-use hazards and stalls upstream when a matched result is not yet available. The selected operands are captured into a valid/ready output register with flush support.

## Interface
- WIDTH, 32, data width of operands and results
- AW, 5, register-address width
- NOPS, 2, source operands per instruction
- NSTG, 2, forwarding stages; index 0 = youngest (EX/MEM), highest priority
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- src_addr  in  NOPS*AW  source register numbers; operand k at [k*AW +: AW]
- src_data  in  NOPS*WIDTH  register-file read data, same packing
- fwd_wen  in  NSTG  stage s will write a register
- fwd_addr  in  NSTG*AW  destination register of stage s
- fwd_data  in  NSTG*WIDTH  result of stage s; meaningful only when not pending
- fwd_pending  in  NSTG  stage s result not yet produced (load in flight)
- flush  in  1  discard held and incoming instruction
- hazard_stall  out  1  load-use hazard on the current input
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  execute consumes the output
- out_data  out  NOPS*WIDTH  selected operands
- out_fwd_hit  out  NOPS  operand k was forwarded rather than read from the register file

## Operation
- Per operand k, search s = 0..NSTG-1; match(s) = fwd_wen[s] && fwd_addr[s] == src_addr[k] && src_addr[k] != 0. The first matching s wins.
- Winner not pending: value = fwd_data[s] and hit = 1. No match: value = src_data[k] and hit = 0.
- src_addr[k] == 0: value = 0 and hit = 0, regardless of src_data or any forward.
- Winner pending: the operand is blocked. A pending match at a lower priority than a non-pending winner does not block.
- hazard_stall = in_valid && any operand blocked. It is combinational.
- in_ready = !flush && !hazard_stall && (!out_valid || out_ready).
- Load (in_valid && in_ready): out_data and out_fwd_hit take the selected values and out_valid <= 1.
- Drain (out_valid && out_ready && no load): out_valid <= 0. out_data holds its last value.
- Flush: out_valid <= 0 next edge. Flush has priority over load and drain. Nothing is captured.
- Hold (out_valid && !out_ready): all outputs are stable.

## Timing
- Reset (rst_n low, asynchronous): out_valid = 0, out_data = 0, out_fwd_hit = 0. The reset is released synchronously through the existing reset synchroniser.
- Latency: one cycle from an accepted input to out_valid.
- Throughput: one instruction per cycle when out_ready is held high and no hazard is present.
- in_ready, hazard_stall and the select path are combinational from the inputs. There is no combinational path from out_ready to out_data.
- Simultaneous load and drain: the new instruction replaces the old one, and out_valid stays 1.
- Reset asserted mid-transfer drops the held instruction. The first accept after release is a clean load.
- When a pending stage clears, the stalled input is accepted in that same cycle, provided the output slot is free.

## Structure
- Shared package pipe_pkg holds REG_ZERO (AW'd0) and the default WIDTH/AW constants, which are reused by the core.
- Sub-module fwd_select: a single-operand priority search, parametrised by WIDTH, AW and NSTG. It outputs value, hit and blocked, and is instantiated NOPS times via generate.
- The top level contains the handshake, the flush logic and the output register.

## Test plan
- Reset and idle: rst_n low mid-cycle -> out_valid = 0, out_data = 0 immediately. in_valid = 0 -> in_ready = 1.
- Priority: src_addr0 = 5, stage0 and stage1 both write r5 with 0xAAAA and 0xBBBB -> out_data0 = 0xAAAA, hit0 = 1, one cycle later.
- Zero register: src_addr1 = 0, src_data = 0x1234, stage0 writes r0 = 0xFFFF -> out_data1 = 0, hit1 = 0.
- Load-use: stage0 pending on r7 and src_addr0 = 7 -> hazard_stall = 1, in_ready = 0 for 2 cycles. When pending drops with fwd_data = 0x55 -> accepted, out_data0 = 0x55.
- Backpressure: out_ready = 0 for 3 cycles with in_valid high -> output held stable, in_ready = 0. Then out_ready = 1 -> back-to-back transfers, no loss or duplicates.
- Flush: assert flush with out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle, and the incoming instruction is not captured.
